// File: rtl/tpu_pkg.sv
// Shared TPU definitions: buffer word width, snapshot size, reader FSM encoding, drain order map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tpu_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  // Sequence index -> snapshot address for the 2x2 matrix.
  // Row-major is the identity; column-major swaps the row and column bits,
  // which gives 0,2,1,3.
  function automatic logic [1:0] order_map(input logic [1:0] idx, input logic transpose);
    return transpose ? {idx[0], idx[1]} : idx;
  endfunction

endpackage

// File: rtl/unified_buffer_reader.sv
// Snapshots the four unified-buffer words on start and streams them out row-major or transposed.
// Latency: first word valid the cycle after an accepted start; one word per handshake, done one cycle after the last word.
// Backpressure: out_ready low holds out_data/out_idx/out_last stable; no data dropped; out_valid has no path from out_ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (all outputs 0 while in reset)
//   start, transpose    drain request and order select, sampled in IDLE only
//   clear               synchronous abort to IDLE, wins over start and handshake
//   u_mem_1..u_mem_4    buffer words at (0,0), (0,1), (1,0), (1,1)
//   out_ready           downstream accept
//   out_data/valid/last/idx   current word stream
//   busy, done          busy in SEND/DONE; done pulses one cycle after the last transfer
module unified_buffer_reader
  import tpu_pkg::*;
#(
  parameter int DATA_W    = tpu_pkg::DATA_W,
  parameter int NUM_WORDS = tpu_pkg::NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              transpose,
  input  logic              clear,
  input  logic [DATA_W-1:0] u_mem_1,
  input  logic [DATA_W-1:0] u_mem_2,
  input  logic [DATA_W-1:0] u_mem_3,
  input  logic [DATA_W-1:0] u_mem_4,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [1:0]        out_idx,
  output logic              busy,
  output logic              done
);

  rd_state_t         state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic              snap_load;
  logic              trans_q;
  logic [DATA_W-1:0] snap [NUM_WORDS];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEND;
          idx_nxt   = 2'd0;
          snap_load = 1'b1;
        end
      end
      SEND: begin
        // out_valid is implied by being in SEND, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (idx == 2'd3) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
    // Abort overrides everything, including a start arriving in the same cycle.
    if (clear) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      snap_load = 1'b0;
    end
  end

  // Snapshot and order latch; only written on an accepted start so the
  // buffer can be rewritten freely while the stream drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        snap[i] <= '0;
      end
    end else if (snap_load) begin
      trans_q <= transpose;
      snap[0] <= u_mem_1;
      snap[1] <= u_mem_2;
      snap[2] <= u_mem_3;
      snap[3] <= u_mem_4;
    end
  end

  // Outputs decode registered state only.
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (idx == 2'd3);
  assign out_idx   = out_valid ? idx : 2'd0;
  assign out_data  = out_valid ? snap[order_map(idx, trans_q)] : '0;
  assign busy      = (state == SEND) || (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_unified_buffer_reader.sv
// Directed bench for unified_buffer_reader: drains, stalls, snapshot isolation, clear, async reset.
// Latency: n/a.
// Backpressure: out_ready driven from directed patterns.
module tb_unified_buffer_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       transpose;
  logic       clear;
  logic [7:0] u_mem_1, u_mem_2, u_mem_3, u_mem_4;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [1:0] out_idx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  unified_buffer_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .transpose (transpose),
    .clear     (clear),
    .u_mem_1   (u_mem_1),
    .u_mem_2   (u_mem_2),
    .u_mem_3   (u_mem_3),
    .u_mem_4   (u_mem_4),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable from here to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] w);
    u_mem_1 = w[31:24];
    u_mem_2 = w[23:16];
    u_mem_3 = w[15:8];
    u_mem_4 = w[7:0];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".data"},  {24'd0, out_data}, 32'd0);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".last"},  {31'd0, out_last}, 32'd0);
    check({tag, ".idx"},   {30'd0, out_idx}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy}, 32'd0);
    check({tag, ".done"},  {31'd0, done}, 32'd0);
  endtask

  // Full drain with out_ready held high; seq holds the expected words, first word in the top byte.
  task automatic run_drain(input string tag, input logic tr, input logic [31:0] seq);
    transpose = tr;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    transpose = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.data%0d", tag, i), {24'd0, out_data}, {24'd0, seq[31-8*i -: 8]});
      check($sformatf("%s.valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s.idx%0d", tag, i), {30'd0, out_idx}, i);
      check($sformatf("%s.last%0d", tag, i), {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("%s.done%0d", tag, i), {31'd0, done}, 32'd0);
      tick();
    end
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".done_busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".done_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".done_data"}, {24'd0, out_data}, 32'd0);
    tick();
    check_idle_outputs({tag, ".after"});
  endtask

  initial begin
    logic [31:0] acc;
    int          nacc;
    int          n22;
    int          nsend;
    int          ndone;

    rst_n     = 1'b0;
    start     = 1'b0;
    transpose = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    set_mem(32'h11223344);
    #1;
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_outputs("idle");

    // Row-major and transposed drains
    run_drain("rowmaj", 1'b0, 32'h11223344);
    run_drain("transp", 1'b1, 32'h11332244);

    // Back-pressure: stall three cycles while idx=1
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    acc = 32'd0; nacc = 0; n22 = 0; nsend = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      if (out_valid) begin
        nsend++;
        if (out_data == 8'h22) n22++;
        if (c == 2) check("bp.stall_idx", {30'd0, out_idx}, 32'd1);
        if (out_ready) begin
          acc = {acc[23:0], out_data};
          nacc++;
        end
      end
      tick();
    end
    out_ready = 1'b1;
    check("bp.words", acc, 32'h11223344);
    check("bp.count", nacc, 32'd4);
    check("bp.hold22", n22, 32'd4);
    check("bp.send_cycles", nsend, 32'd7);

    // Snapshot isolation: rewrite buffer and pulse start mid-stream
    set_mem(32'h11223344);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_mem(32'hAABBCCDD);
    acc = 32'd0; nacc = 0; ndone = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 1) || (c == 4);   // c==4 is the DONE cycle
      if (out_valid) begin
        acc = {acc[23:0], out_data};
        nacc++;
      end
      if (done) ndone++;
      tick();
    end
    start = 1'b0;
    check("iso.words", acc, 32'h11223344);
    check("iso.count", nacc, 32'd4);
    check("iso.done_count", ndone, 32'd1);

    // Clear wins over start in IDLE
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_start.valid", {31'd0, out_valid}, 32'd0);

    // Clear at idx=2
    set_mem(32'h11223344);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("clr.idx2", {30'd0, out_idx}, 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_outputs("clr");
    tick();
    check("clr.no_done", {31'd0, done}, 32'd0);
    set_mem(32'h55667788);
    run_drain("clr_fresh", 1'b1, 32'h55776688);

    // Asynchronous reset in the middle of SEND
    set_mem(32'h11223344);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_mid.pre_idx", {30'd0, out_idx}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || out_valid) ndone++;
    end
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done || out_valid) ndone++;
    end
    check("rst_mid.no_done", ndone, 32'd0);
    run_drain("post_rst", 1'b0, 32'h11223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
